// File: rtl/ni_dma_if.sv
// ni_dma_if: bundles every non-clock/reset signal of the NoC DMA engine.
//   slave  - the DMA engine side (ni_dma)
//   master - the environment side (CPU control, router link, RAM port B)
// Groups: RX control (rx_*), TX control (tx_*), router link (noc_rx_*, noc_tx_*),
// RAM port B (mem_addr, mem_data, mem_wb, mem_rdata).
interface ni_dma_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  rx_start;
    logic [ADDR_WIDTH-1:0] rx_base;
    logic                  rx_busy;
    logic                  rx_done;
    logic [15:0]           rx_count;
    logic                  tx_start;
    logic [ADDR_WIDTH-1:0] tx_base;
    logic                  tx_busy;
    logic                  tx_done;
    logic [31:0]           noc_rx_data;
    logic                  noc_rx_valid;
    logic                  noc_rx_ready;
    logic [31:0]           noc_tx_data;
    logic                  noc_tx_valid;
    logic                  noc_tx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;
    logic [3:0]            mem_wb;
    logic [31:0]           mem_rdata;

    modport slave (
        input  rx_start, rx_base, tx_start, tx_base,
        input  noc_rx_data, noc_rx_valid, noc_tx_ready, mem_rdata,
        output rx_busy, rx_done, rx_count, tx_busy, tx_done,
        output noc_rx_ready, noc_tx_data, noc_tx_valid,
        output mem_addr, mem_data, mem_wb
    );

    modport master (
        output rx_start, rx_base, tx_start, tx_base,
        output noc_rx_data, noc_rx_valid, noc_tx_ready, mem_rdata,
        input  rx_busy, rx_done, rx_count, tx_busy, tx_done,
        input  noc_rx_ready, noc_tx_data, noc_tx_valid,
        input  mem_addr, mem_data, mem_wb
    );
endinterface

// File: rtl/ni_dma.sv
// ni_dma: NoC <-> RAM port B DMA engine.
//   RX: writes a received packet (header + L payload flits) to RAM at rx_base.
//   TX: reads a packet from RAM at tx_base and streams it to the router.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - ni_dma_if.slave (control, router link, RAM port B)
module ni_dma #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic    clock,
    input  logic    reset,
    ni_dma_if.slave bus
);
    localparam logic [1:0] R_IDLE = 2'd0, R_HDR = 2'd1, R_BODY = 2'd2;
    localparam logic [1:0] T_IDLE = 2'd0, T_HDR = 2'd1, T_WAIT = 2'd2, T_BODY = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    // ---------------- RX engine ----------------
    logic [1:0]            rx_state;
    logic [ADDR_WIDTH-1:0] rx_ptr;
    logic [15:0]           rx_left;
    logic [15:0]           rx_cnt;
    logic                  rx_done_q;
    logic                  rx_hs;

    assign bus.noc_rx_ready = (rx_state != R_IDLE);
    assign bus.rx_busy      = (rx_state != R_IDLE);
    assign bus.rx_done      = rx_done_q;
    assign bus.rx_count     = rx_cnt;
    assign rx_hs            = bus.noc_rx_valid & bus.noc_rx_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state  <= R_IDLE;
            rx_ptr    <= '0;
            rx_left   <= '0;
            rx_cnt    <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state)
                R_IDLE: if (bus.rx_start) begin
                    rx_state <= R_HDR;
                    rx_ptr   <= bus.rx_base;
                    rx_cnt   <= '0;
                end
                R_HDR: if (rx_hs) begin
                    rx_ptr  <= rx_ptr + ONE;
                    rx_cnt  <= rx_cnt + 16'd1;
                    rx_left <= bus.noc_rx_data[15:0];
                    if (bus.noc_rx_data[15:0] == 16'd0) begin
                        rx_state  <= R_IDLE;
                        rx_done_q <= 1'b1;
                    end else begin
                        rx_state <= R_BODY;
                    end
                end
                R_BODY: if (rx_hs) begin
                    rx_ptr  <= rx_ptr + ONE;
                    rx_cnt  <= rx_cnt + 16'd1;
                    rx_left <= rx_left - 16'd1;
                    if (rx_left == 16'd1) begin
                        rx_state  <= R_IDLE;
                        rx_done_q <= 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    logic [1:0]            tx_state;
    logic [ADDR_WIDTH-1:0] tx_ptr;     // next read address
    logic [15:0]           rd_left;    // body reads still to issue
    logic [16:0]           tx_left;    // flits still to hand to the router (1+L fits 17 bits)
    logic                  inflight;   // read issued last cycle, data on mem_rdata now
    logic                  tx_done_q;
    logic                  tx_issue;
    logic                  room;

    logic [1:0][31:0]      fifo_mem;
    logic                  wr_idx, rd_idx;
    logic [1:0]            fifo_cnt;
    logic                  push, pop;

    assign push = inflight;
    assign pop  = (fifo_cnt != 2'd0) & bus.noc_tx_ready;

    // Occupancy next cycle is cnt + inflight - pop; a read issued now lands
    // then, so it must leave that below 2. Counting the pop keeps 1 flit/cycle.
    assign room = ({1'b0, fifo_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

    // RX writes own port B; TX reads only fill idle cycles.
    assign tx_issue = !rx_hs &&
                      ((tx_state == T_HDR) ||
                       (tx_state == T_BODY && rd_left != 16'd0 && room));

    assign bus.tx_busy      = (tx_state != T_IDLE);
    assign bus.tx_done      = tx_done_q;
    assign bus.noc_tx_valid = (fifo_cnt != 2'd0);
    assign bus.noc_tx_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_idx] : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state  <= T_IDLE;
            tx_ptr    <= '0;
            rd_left   <= '0;
            tx_left   <= '0;
            inflight  <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            inflight  <= tx_issue;
            if (tx_issue) tx_ptr <= tx_ptr + ONE;
            case (tx_state)
                T_IDLE: if (bus.tx_start) begin
                    tx_state <= T_HDR;
                    tx_ptr   <= bus.tx_base;
                end
                T_HDR: if (tx_issue) tx_state <= T_WAIT;
                T_WAIT: begin
                    // header is on mem_rdata and is pushed to the FIFO this cycle
                    rd_left  <= bus.mem_rdata[15:0];
                    tx_left  <= {1'b0, bus.mem_rdata[15:0]} + 17'd1;
                    tx_state <= T_BODY;
                end
                T_BODY: begin
                    if (tx_issue) rd_left <= rd_left - 16'd1;
                    if (pop) begin
                        tx_left <= tx_left - 17'd1;
                        if (tx_left == 17'd1) begin
                            tx_state  <= T_IDLE;
                            tx_done_q <= 1'b1;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_mem <= '0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= bus.mem_rdata;
                wr_idx           <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- port B mux ----------------
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_data = 32'd0;
        bus.mem_wb   = 4'h0;
        if (rx_hs) begin
            bus.mem_addr = rx_ptr;
            bus.mem_data = bus.noc_rx_data;
            bus.mem_wb   = 4'hF;
        end else if (tx_issue) begin
            bus.mem_addr = tx_ptr;
        end
    end
endmodule
